// File: rtl/host_cmd_engine.sv
// host_cmd_engine: parses opcode-framed host bytes into register-bus writes
// and reads, streaming read results back on a separate byte channel.
module host_cmd_engine #(
  parameter int DATA_BYTES = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    HOST_RTS,
  input  logic [7:0]              HOST_DATA,
  output logic                    HOST_RTR,
  output logic                    REG_WE,
  output logic                    REG_RE,
  output logic [8*DATA_BYTES-1:0] REG_DATA,
  output logic [3:0]              ENGINE_ID,
  output logic [3:0]              REG_ADDR,
  input  logic [8*DATA_BYTES-1:0] REG_RDATA,
  input  logic                    REG_RVALID,
  output logic                    TX_RTS,
  output logic [7:0]              TX_DATA,
  input  logic                    TX_RTR,
  input  logic                    CLR_ERR,
  output logic                    ERR_OPCODE,
  output logic                    ERR_TIMEOUT
);

  localparam int IW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BYTES - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);
  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;

  typedef enum logic [2:0] {IDLE, HDR, WDATA, WSTB, RREQ, RWAIT, RSEND} state_t;

  state_t state_reg, state_next;

  logic                    host_rtr_reg;
  logic                    is_read_reg;
  logic [3:0]              engine_id_reg;
  logic [3:0]              reg_addr_reg;
  logic [IW-1:0]           widx_reg;
  logic [IW-1:0]           tidx_reg;
  logic [CW-1:0]           cnt_reg;
  logic                    err_opcode_reg;
  logic                    err_timeout_reg;
  logic [8*DATA_BYTES-1:0] rbuf_flat;

  logic host_xfer;
  logic tx_xfer;
  logic good_op;
  logic bad_op;
  logic rd_hit;
  logic rd_expire;

  // Handshake qualifiers and event decodes shared by FSM and datapath.
  assign host_xfer = HOST_RTS && host_rtr_reg;
  assign tx_xfer   = (state_reg == RSEND) && TX_RTR;
  assign good_op   = (HOST_DATA == OP_WRITE) || (HOST_DATA == OP_READ);
  assign bad_op    = (state_reg == IDLE) && host_xfer && !good_op;
  assign rd_hit    = (state_reg == RWAIT) && REG_RVALID;
  assign rd_expire = (state_reg == RWAIT) && !REG_RVALID && (cnt_reg == LAST_CNT);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (host_xfer && good_op) state_next = HDR;
      HDR:     if (host_xfer) state_next = is_read_reg ? RREQ : WDATA;
      WDATA:   if (host_xfer && (widx_reg == LAST_IDX)) state_next = WSTB;
      WSTB:    state_next = IDLE;
      RREQ:    state_next = RWAIT;
      RWAIT:   if (rd_hit || rd_expire) state_next = RSEND;
      RSEND:   if (tx_xfer && (tidx_reg == LAST_IDX)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control registers: host ready, header fields, byte indices, timeout counter, sticky errors.
  always_ff @(posedge clk) begin
    if (reset) begin
      host_rtr_reg    <= 1'b0;
      is_read_reg     <= 1'b0;
      engine_id_reg   <= '0;
      reg_addr_reg    <= '0;
      widx_reg        <= '0;
      tidx_reg        <= '0;
      cnt_reg         <= '0;
      err_opcode_reg  <= 1'b0;
      err_timeout_reg <= 1'b0;
    end else begin
      host_rtr_reg <= (state_next == IDLE) || (state_next == HDR) || (state_next == WDATA);
      if ((state_reg == IDLE) && host_xfer && good_op)
        is_read_reg <= (HOST_DATA == OP_READ);
      if ((state_reg == HDR) && host_xfer) begin
        engine_id_reg <= HOST_DATA[7:4];
        reg_addr_reg  <= HOST_DATA[3:0];
        widx_reg      <= '0;
      end
      if ((state_reg == WDATA) && host_xfer)
        widx_reg <= widx_reg + 1'b1;
      if (state_reg == RREQ) begin
        cnt_reg  <= '0;
        tidx_reg <= '0;
      end
      if ((state_reg == RWAIT) && !REG_RVALID)
        cnt_reg <= cnt_reg + 1'b1;
      if (tx_xfer)
        tidx_reg <= tidx_reg + 1'b1;
      // A set in the same cycle as a clear keeps the flag high.
      err_opcode_reg  <= bad_op    ? 1'b1 : (CLR_ERR ? 1'b0 : err_opcode_reg);
      err_timeout_reg <= rd_expire ? 1'b1 : (CLR_ERR ? 1'b0 : err_timeout_reg);
    end
  end

  // One byte lane per payload byte: write word assembly and read response buffer.
  for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_lane
    logic [7:0] wbyte_reg;
    logic [7:0] rbyte_reg;

    // Capture this lane's host payload byte, and the read data or all-ones on timeout.
    always_ff @(posedge clk) begin
      if (reset) begin
        wbyte_reg <= '0;
        rbyte_reg <= '0;
      end else begin
        if ((state_reg == WDATA) && host_xfer && (widx_reg == IW'(gi)))
          wbyte_reg <= HOST_DATA;
        if (rd_hit)
          rbyte_reg <= REG_RDATA[8*gi +: 8];
        else if (rd_expire)
          rbyte_reg <= 8'hFF;
      end
    end

    assign REG_DATA[8*gi +: 8]  = wbyte_reg;
    assign rbuf_flat[8*gi +: 8] = rbyte_reg;
  end

  // Response byte select; the index only moves on a TX transfer so the byte holds under backpressure.
  always_comb begin
    TX_DATA = 8'h00;
    for (int i = 0; i < DATA_BYTES; i++)
      if (tidx_reg == IW'(i)) TX_DATA = rbuf_flat[8*i +: 8];
  end

  assign HOST_RTR    = host_rtr_reg;
  assign REG_WE      = (state_reg == WSTB);
  assign REG_RE      = (state_reg == RREQ);
  assign TX_RTS      = (state_reg == RSEND);
  assign ENGINE_ID   = engine_id_reg;
  assign REG_ADDR    = reg_addr_reg;
  assign ERR_OPCODE  = err_opcode_reg;
  assign ERR_TIMEOUT = err_timeout_reg;

endmodule

// File: tb/tb_host_cmd_engine.sv
// Testbench for host_cmd_engine: randomized frames against a frame-level
// reference model, with a scoreboard monitor checking every DUT output event.
module tb_host_cmd_engine;
  localparam int DB = 4;
  localparam int TO = 8;
  localparam int W  = 8 * DB;

  logic         clk = 1'b0;
  logic         reset;
  logic         HOST_RTS;
  logic [7:0]   HOST_DATA;
  logic         HOST_RTR;
  logic         REG_WE;
  logic         REG_RE;
  logic [W-1:0] REG_DATA;
  logic [3:0]   ENGINE_ID;
  logic [3:0]   REG_ADDR;
  logic [W-1:0] REG_RDATA;
  logic         REG_RVALID;
  logic         TX_RTS;
  logic [7:0]   TX_DATA;
  logic         TX_RTR;
  logic         CLR_ERR;
  logic         ERR_OPCODE;
  logic         ERR_TIMEOUT;

  always #5 clk = ~clk;

  host_cmd_engine #(.DATA_BYTES(DB), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .HOST_RTS(HOST_RTS), .HOST_DATA(HOST_DATA), .HOST_RTR(HOST_RTR),
    .REG_WE(REG_WE), .REG_RE(REG_RE), .REG_DATA(REG_DATA),
    .ENGINE_ID(ENGINE_ID), .REG_ADDR(REG_ADDR),
    .REG_RDATA(REG_RDATA), .REG_RVALID(REG_RVALID),
    .TX_RTS(TX_RTS), .TX_DATA(TX_DATA), .TX_RTR(TX_RTR),
    .CLR_ERR(CLR_ERR), .ERR_OPCODE(ERR_OPCODE), .ERR_TIMEOUT(ERR_TIMEOUT)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard queues filled at stimulus time.
  logic [W+7:0] q_we[$];
  logic [7:0]   q_rd[$];
  logic [7:0]   q_tx[$];

  // Model of sticky error flags.
  bit exp_err_op = 1'b0;
  bit exp_err_to = 1'b0;

  // Engine responder configuration: delay 0 means never answer.
  int           rsp_delay = 0;
  logic [W-1:0] rsp_data  = '0;
  bit           tx_toggle = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got event/timeout, expected none", name);
  endtask

  // Monitor: compares every output event against the scoreboard.
  initial begin
    logic [W+7:0] ew;
    logic [7:0]   er;
    forever begin
      @(negedge clk);
      if (REG_WE) begin
        check("host_rtr_in_wstb", HOST_RTR, 1'b0);
        if (q_we.size() == 0) fail_now("unexpected_reg_we");
        else begin
          ew = q_we.pop_front();
          check("reg_we_word", {ENGINE_ID, REG_ADDR, REG_DATA}, ew);
          $display("write eng=%0h addr=%0h data=%08h", ENGINE_ID, REG_ADDR, REG_DATA);
        end
      end
      if (REG_RE) begin
        check("host_rtr_in_rreq", HOST_RTR, 1'b0);
        if (q_rd.size() == 0) fail_now("unexpected_reg_re");
        else begin
          er = q_rd.pop_front();
          check("reg_re_target", {ENGINE_ID, REG_ADDR}, er);
          $display("read  eng=%0h addr=%0h", ENGINE_ID, REG_ADDR);
        end
      end
      if (TX_RTS) begin
        check("host_rtr_in_rsend", HOST_RTR, 1'b0);
        if (q_tx.size() == 0) fail_now("unexpected_tx_byte");
        else begin
          check("tx_data", TX_DATA, q_tx[0]);
          if (TX_RTR) begin
            void'(q_tx.pop_front());
            $display("tx    byte=%02h", TX_DATA);
          end
        end
      end
    end
  end

  // Engine responder: answers REG_RE after rsp_delay cycles.
  initial begin
    REG_RVALID = 1'b0;
    REG_RDATA  = '0;
    forever begin
      @(negedge clk);
      if (REG_RE && rsp_delay != 0) begin
        repeat (rsp_delay) @(posedge clk);
        #1;
        REG_RVALID = 1'b1;
        REG_RDATA  = rsp_data;
        @(posedge clk);
        #1;
        REG_RVALID = 1'b0;
        REG_RDATA  = W'($urandom);
      end
    end
  end

  // Host-side TX ready: random or strict toggling.
  initial begin
    TX_RTR = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      TX_RTR = tx_toggle ? ~TX_RTR : ($urandom_range(0, 3) != 0);
    end
  end

  // Watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    HOST_DATA = b;
    HOST_RTS  = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (HOST_RTR) done = 1'b1;
      else begin
        n++;
        if (n > 100) begin
          fail_now("host_rtr_wait");
          done = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    HOST_RTS  = 1'b0;
    HOST_DATA = 8'($urandom);
  endtask

  task automatic gap(input int maxgap);
    int g;
    g = $urandom_range(0, maxgap);
    repeat (g) @(posedge clk);
    if (g > 0) #1;
  endtask

  task automatic write_frame(input logic [3:0] eng, input logic [3:0] addr,
                             input logic [W-1:0] data, input int maxgap);
    q_we.push_back({eng, addr, data});
    send_byte(8'h01);
    gap(maxgap);
    send_byte({eng, addr});
    for (int i = 0; i < DB; i++) begin
      gap(maxgap);
      send_byte(data[8*i +: 8]);
    end
  endtask

  task automatic read_frame(input logic [3:0] eng, input logic [3:0] addr,
                            input logic [W-1:0] data, input int delay);
    bit ok;
    ok = (delay >= 1) && (delay <= TO);
    rsp_delay = delay;
    rsp_data  = data;
    q_rd.push_back({eng, addr});
    for (int i = 0; i < DB; i++) q_tx.push_back(ok ? data[8*i +: 8] : 8'hFF);
    if (!ok) exp_err_to = 1'b1;
    send_byte(8'h02);
    send_byte({eng, addr});
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q_we.size() != 0 || q_rd.size() != 0 || q_tx.size() != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) fail_now("wait_idle_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_err_opcode"}, ERR_OPCODE, exp_err_op);
    check({tag, "_err_timeout"}, ERR_TIMEOUT, exp_err_to);
  endtask

  task automatic clear_pulse();
    CLR_ERR = 1'b1;
    @(posedge clk);
    #1;
    CLR_ERR = 1'b0;
    exp_err_op = 1'b0;
    exp_err_to = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_host_rtr"}, HOST_RTR, 1'b0);
    check({tag, "_reg_we"}, REG_WE, 1'b0);
    check({tag, "_reg_re"}, REG_RE, 1'b0);
    check({tag, "_reg_data"}, REG_DATA, '0);
    check({tag, "_engine_id"}, ENGINE_ID, 4'h0);
    check({tag, "_reg_addr"}, REG_ADDR, 4'h0);
    check({tag, "_tx_rts"}, TX_RTS, 1'b0);
    check({tag, "_tx_data"}, TX_DATA, 8'h00);
    check_flags(tag);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_err_op = 1'b0;
    exp_err_to = 1'b0;
  endtask

  // Stimulus.
  initial begin
    int           kind;
    int           d;
    logic [3:0]   eng;
    logic [3:0]   addr;
    logic [W-1:0] data;

    reset     = 1'b1;
    HOST_RTS  = 1'b0;
    HOST_DATA = 8'h00;
    CLR_ERR   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_state("reset");

    // Back-to-back write.
    write_frame(4'h3, 4'h5, 32'hDEADBEEF, 0);
    wait_idle();

    // Writes with host gaps.
    for (int i = 0; i < 3; i++) begin
      write_frame(4'($urandom), 4'($urandom), W'($urandom), 3);
      wait_idle();
    end

    // Read answered after three cycles with toggling TX ready.
    tx_toggle = 1'b1;
    read_frame(4'hA, 4'h7, 32'h12345678, 3);
    wait_idle();
    check("host_rtr_after_tx", HOST_RTR, 1'b1);
    check_flags("read_ok");

    // Read never answered: timeout response.
    read_frame(4'h4, 4'h1, 32'h0BADF00D, 0);
    wait_idle();
    check_flags("timeout");

    // Bad opcode while clearing: set wins for opcode, timeout flag clears.
    CLR_ERR = 1'b1;
    send_byte(8'hC3);
    CLR_ERR = 1'b0;
    exp_err_op = 1'b1;
    exp_err_to = 1'b0;
    check_flags("set_vs_clear");
    clear_pulse();
    check_flags("clear");
    tx_toggle = 1'b0;

    // Bad opcode then a normal write.
    send_byte(8'h7F);
    exp_err_op = 1'b1;
    write_frame(4'h1, 4'h2, 32'h01020304, 0);
    wait_idle();
    check_flags("bad_opcode");

    // Timeout boundary: data on the last wait cycle wins, one later times out.
    clear_pulse();
    read_frame(4'h6, 4'h6, 32'hCAFE0001, TO);
    wait_idle();
    check_flags("rvalid_at_expiry");
    read_frame(4'h6, 4'h7, 32'hCAFE0002, TO + 1);
    wait_idle();
    check_flags("rvalid_after_expiry");
    read_frame(4'h2, 4'h9, 32'hA5A55A5A, 1);
    wait_idle();

    // Reset after the third payload byte drops the frame.
    send_byte(8'h01);
    send_byte(8'h9C);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    pulse_reset();
    check_reset_state("mid_reset");
    write_frame(4'h8, 4'hE, 32'h55667788, 1);
    wait_idle();
    check_flags("after_reset");

    // Randomized frames.
    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 9);
      eng  = 4'($urandom);
      addr = 4'($urandom);
      data = W'($urandom);
      tx_toggle = ($urandom_range(0, 1) == 1);
      if (kind < 5) write_frame(eng, addr, data, 3);
      else if (kind < 9) begin
        d = $urandom_range(0, TO + 2);
        read_frame(eng, addr, data, d);
      end else begin
        send_byte(8'($urandom_range(3, 255)));
        exp_err_op = 1'b1;
      end
      wait_idle();
      if ($urandom_range(0, 3) == 0) clear_pulse();
      check_flags("random");
    end

    repeat (5) @(posedge clk);
    #1;
    check("final_we_queue_empty", 64'(q_we.size()), 64'd0);
    check("final_tx_queue_empty", 64'(q_tx.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/host_cmd_engine.md
Name: host_cmd_engine

Overview:
Parametrised successor to the host byte-stream command processor. Parses opcode-framed host byte commands into register-bus writes and reads for the engines. Write frames assemble a DATA_BYTES-wide word LSB-first and pulse a write strobe. Read frames issue a read strobe, wait for read data with a timeout, and stream the result back to the host byte-wise on a second RTS/RTR channel. Bad opcodes and timeouts raise sticky error flags.

Parameters:
DATA_BYTES, 4, payload bytes per register word; REG_DATA width = 8*DATA_BYTES; legal range 1..8.
TIMEOUT, 255, cycles spent in RWAIT without REG_RVALID before the read aborts; must be ≥1.

Ports:
clk  in  1  clock; all logic on posedge.
reset  in  1  synchronous, active-high reset.
HOST_RTS  in  1  host byte valid.
HOST_DATA  in  8  host byte.
HOST_RTR  out  1  block ready for a host byte; a transfer occurs when HOST_RTS && HOST_RTR.
REG_WE  out  1  one-cycle register write strobe.
REG_RE  out  1  one-cycle register read strobe.
REG_DATA  out  8*DATA_BYTES  assembled write word.
ENGINE_ID  out  4  target engine.
REG_ADDR  out  4  target register.
REG_RDATA  in  8*DATA_BYTES  read data from the engine.
REG_RVALID  in  1  REG_RDATA valid; sampled only in RWAIT.
TX_RTS  out  1  response byte valid.
TX_DATA  out  8  response byte.
TX_RTR  in  1  host ready; a transfer occurs when TX_RTS && TX_RTR.
CLR_ERR  in  1  clears both sticky error flags.
ERR_OPCODE  out  1  sticky: unknown opcode received.
ERR_TIMEOUT  out  1  sticky: read timed out.

Behaviour:
- Frame format: byte0 = opcode (0x01 write, 0x02 read). byte1 = {ENGINE_ID[7:4], REG_ADDR[3:0]}. A write frame then carries DATA_BYTES payload bytes, LSB first. A read frame has no payload.
- States: IDLE, HDR, WDATA, WSTB, RREQ, RWAIT, RSEND.
- Reset: state=IDLE. All outputs are 0, including REG_DATA and TX_DATA, and the error flags clear.
- Reset mid-frame: the frame is dropped with no REG_WE or REG_RE pulse. The partial REG_DATA is cleared.
- HOST_RTR is registered. Its next value is 1 iff the next state is IDLE, HDR or WDATA. It is therefore 0 in the first cycle after reset and 0 throughout WSTB, RREQ, RWAIT and RSEND.
- IDLE, transfer of 0x01 or 0x02: latch the op, go to HDR.
- IDLE, transfer of any other opcode: set ERR_OPCODE, discard the byte, stay in IDLE.
- HDR, transfer: latch ENGINE_ID and REG_ADDR. Go to WDATA (write) or RREQ (read).
- WDATA: the byte index starts at 0. Each transfer writes REG_DATA[8*i +: 8] and increments the index. The transfer of byte DATA_BYTES-1 moves to WSTB.
- WSTB: REG_WE=1 for exactly this one cycle, then go to IDLE.
  - Latency: REG_WE is high in the cycle after the last payload transfer.
  - REG_DATA, ENGINE_ID and REG_ADDR hold their values until overwritten by the next frame.
- RREQ: REG_RE=1 for exactly one cycle. Clear the timeout counter, then go to RWAIT.
- RWAIT, REG_RVALID=1: capture REG_RDATA into the response buffer, go to RSEND.
- RWAIT, no REG_RVALID: the counter increments each cycle. When the counter reaches TIMEOUT-1 without RVALID, load an all-ones response, set ERR_TIMEOUT and go to RSEND. The total wait is TIMEOUT cycles.
- RWAIT: if REG_RVALID arrives in the same cycle as expiry, the data wins and ERR_TIMEOUT is not set.
- RSEND: TX_RTS=1 and TX_DATA = buffer byte k, starting at k=0 (LSB first). Each TX transfer increments k. The transfer of byte DATA_BYTES-1 goes to IDLE with TX_RTS=0 the next cycle. TX_DATA is held stable while TX_RTR=0.
- Error flags: set as above. CLR_ERR=1 clears both flags on the next edge. If a set and a clear occur in the same cycle, the set wins.
- HOST_RTS is ignored in every state where HOST_RTR=0; no byte is consumed.

Test Plan:
- Write frame 01,35,EF,BE,AD,DE, DATA_BYTES=4, back-to-back → one REG_WE pulse with ENGINE_ID=3, REG_ADDR=5, REG_DATA=0xDEADBEEF; HOST_RTR=0 during WSTB.
- Write frame with HOST_RTS gaps of 0–3 cycles between bytes → same result, exactly one REG_WE pulse.
- Read 02,A7 with REG_RVALID=1 and REG_RDATA=0x12345678 three cycles after REG_RE → TX bytes 78,56,34,12; TX_RTR toggled each cycle holds TX_DATA stable; HOST_RTR=1 after the last TX byte.
- Read with REG_RVALID never asserted, TIMEOUT=8 → RSEND after 8 RWAIT cycles, TX bytes FF×4, ERR_TIMEOUT=1; CLR_ERR pulse → 0.
- Opcode 0x7F then write frame 01,12,04,03,02,01 → ERR_OPCODE=1, then REG_WE with 0x01020304 to engine 1, register 2.
- reset asserted after the third payload byte → no REG_WE, all outputs 0. A following full write frame completes correctly.
